// File: rtl/rv32_mod_load_store_unit.sv
// Load/store unit for the rv32imc single-stage core.
// Issues one word-addressed bus access at a time, with byte enables and lane-replicated
// store data, and returns sign- or zero-extended load data as a one-cycle response pulse.
// Optional feature macro: RV32_LSU_MISALIGN_TRAP_EN (misaligned half/word accesses fault
// instead of being truncated to natural alignment).
module rv32_mod_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // 9 bits so the compare against 255 cannot wrap.
    localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        bus_wr_q, bus_wr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        illegal;
    logic        timeout_hit;
    logic [1:0]  lane_sel;
    logic [3:0]  be_sel;
    logic [31:0] wdata_sel;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    // Decode legality and lane placement of the incoming request.
    always_comb begin
        illegal   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111) || (req_wr && req_funct3[2]);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        illegal   = illegal ||
                    ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
        lane_sel  = 2'b00;
        be_sel    = 4'b1111;
        wdata_sel = req_wdata;
        unique case (req_funct3[1:0])
            2'b00: begin
                lane_sel  = req_addr[1:0];
                be_sel    = 4'b0001 << req_addr[1:0];
                wdata_sel = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                // Misaligned halves are truncated to the half-word boundary.
                lane_sel  = {req_addr[1], 1'b0};
                be_sel    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_sel = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_sel  = 2'b00;
                be_sel    = 4'b1111;
                wdata_sel = req_wdata;
            end
        endcase
    end

    // Align the returned word to the accessed lane and extend it.
    always_comb begin
        rdata_shift = bus_rdata >> {lane_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'b0, rdata_shift[7:0]};
            3'b101:  load_data = {16'b0, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    // Expiry on the cycle the counter would reach the limit; 0 disables.
    assign timeout_hit = (TimeoutLim != 9'd0) && (({1'b0, cnt_q} + 9'd1) == TimeoutLim);

    // Next-state logic: FSM, timeout counter, bus request capture and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (illegal) begin
                        state_d      = StResp;
                        resp_rdata_d = 32'b0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = StBus;
                        cnt_d       = 8'd0;
                        lane_d      = lane_sel;
                        funct3_d    = req_funct3;
                        bus_wr_d    = req_wr;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = be_sel;
                        bus_wdata_d = wdata_sel;
                    end
                end
            end
            StBus: begin
                if (bus_err) begin
                    state_d      = StResp;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b1;
                end else if (bus_ack) begin
                    state_d      = StResp;
                    resp_rdata_d = bus_wr_q ? 32'b0 : load_data;
                    resp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d      = StResp;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= 32'b0;
            bus_be_q     <= 4'b0;
            bus_wdata_q  <= 32'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Outputs decoded directly from state so they drop with an asynchronous reset.
    always_comb begin
        req_ready  = (state_q == StIdle);
        stall      = (state_q != StIdle);
        bus_req    = (state_q == StBus);
        resp_valid = (state_q == StResp);
        resp_err   = (state_q == StResp) && resp_err_q;
        resp_rdata = resp_rdata_q;
        bus_wr     = bus_wr_q;
        bus_addr   = bus_addr_q;
        bus_be     = bus_be_q;
        bus_wdata  = bus_wdata_q;
    end

endmodule
